// File: rtl/sim_eoc_trace_ctrl_pkg.sv
// Shared definitions for the EOC / trace-window register slave.
package sim_eoc_trace_ctrl_pkg;

    // Word offsets decoded from addr[4:2]
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_TRACE_LEN = 3'd1;
    localparam logic [2:0] REG_EXIT      = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_WIN_CNT   = 3'd4;

    // CTRL write-one pulse bits
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_STOP_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } trace_state_e;

endpackage

// File: rtl/sim_trace_window_cnt.sv
// Trace window FSM: window cycle counter, length compare, holdoff timer,
// start-pending flag and saturating count of opened windows.
module sim_trace_window_cnt
    import sim_eoc_trace_ctrl_pkg::*;
#(
    parameter int unsigned LenWidth      = 32,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned HoldoffCycles = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_close,
    input  logic [LenWidth-1:0] i_trace_len,
    output trace_state_e        o_state,
    output logic                o_start_pend,
    output logic                o_trace_en,
    output logic [LenWidth-1:0] o_win_cnt,
    output logic [CntWidth-1:0] o_windows
);

    localparam int unsigned HoldW = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldoffCycles - 1);

    trace_state_e        r_state;
    trace_state_e        w_state_nxt;
    logic                r_trace_en;
    logic                r_start_pend;
    logic [LenWidth-1:0] r_win_cnt;
    logic [CntWidth-1:0] r_windows;
    logic [HoldW-1:0]    r_hold;
    logic                w_len_hit;
    logic                w_open;

    // Length reached: compare with >= so a shrinking TRACE_LEN closes on the next cycle
    always_comb begin
        w_len_hit = (i_trace_len != '0) && (r_win_cnt >= (i_trace_len - LenWidth'(1)));
    end

    // Next-state logic; STOP overrides START and any pending start
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!i_stop && (i_start || r_start_pend)) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (i_stop || i_close || w_len_hit) begin
                    w_state_nxt = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (r_hold == HoldLast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_open = (r_state == IDLE) && (w_state_nxt == ACTIVE);
    end

    // State register with registered trace enable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_trace_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_trace_en <= (w_state_nxt == ACTIVE);
        end
    end

    // Start-pending flag: set by START during holdoff, consumed on window open
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_pend <= 1'b0;
        end else if (i_stop) begin
            r_start_pend <= 1'b0;
        end else if ((r_state == HOLDOFF) && i_start) begin
            r_start_pend <= 1'b1;
        end else if (w_open) begin
            r_start_pend <= 1'b0;
        end
    end

    // Window cycle counter, opened-window counter and holdoff timer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win_cnt <= '0;
            r_windows <= '0;
            r_hold    <= '0;
        end else begin
            if (w_open) begin
                r_win_cnt <= '0;
                if (r_windows != '1) begin
                    r_windows <= r_windows + CntWidth'(1);
                end
            end else if (r_state == ACTIVE) begin
                r_win_cnt <= r_win_cnt + LenWidth'(1);
            end
            if (r_state != HOLDOFF) begin
                r_hold <= '0;
            end else begin
                r_hold <= r_hold + HoldW'(1);
            end
        end
    end

    assign o_state      = r_state;
    assign o_start_pend = r_start_pend;
    assign o_trace_en   = r_trace_en;
    assign o_win_cnt    = r_win_cnt;
    assign o_windows    = r_windows;

endmodule

// File: rtl/sim_eoc_trace_ctrl.sv
// Register slave for end-of-computation reporting and trace-window control.
module sim_eoc_trace_ctrl
    import sim_eoc_trace_ctrl_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned LenWidth      = 32,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned HoldoffCycles = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 trace_en_o,
    output logic                 eoc_valid_o,
    input  logic                 eoc_ack_i,
    output logic [30:0]          exit_code_o
);

    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_error;
    logic                r_start;
    logic                r_stop;
    logic                r_close;
    logic [LenWidth-1:0] r_trace_len;
    logic                r_eoc_valid;
    logic [30:0]         r_exit_code;

    logic                w_acc;
    logic [2:0]          w_off;
    logic [31:0]         w_rdata;
    logic                w_err;
    logic                w_start;
    logic                w_stop;
    logic                w_exit;
    logic [31:0]         w_len32;
    logic [LenWidth-1:0] w_len_nxt;
    logic [31:0]         w_status;
    trace_state_e        w_state;
    logic                w_start_pend;
    logic [LenWidth-1:0] w_win_cnt;
    logic [CntWidth-1:0] w_windows;
    logic                w_unused_addr;

    assign w_unused_addr = ^{req_addr_i[AddrWidth-1:5], req_addr_i[1:0]};
    assign w_acc         = req_valid_i && !r_rsp_valid;
    assign w_off         = req_addr_i[4:2];

    // STATUS word assembly
    always_comb begin
        w_status                  = '0;
        w_status[1:0]             = w_state;
        w_status[2]               = r_eoc_valid;
        w_status[3]               = w_start_pend;
        w_status[16 +: CntWidth]  = w_windows;
    end

    // Request decode: read data, error and write side-effect strobes
    always_comb begin
        w_rdata   = '0;
        w_err     = 1'b0;
        w_start   = 1'b0;
        w_stop    = 1'b0;
        w_exit    = 1'b0;
        w_len32   = 32'(r_trace_len);
        w_len_nxt = r_trace_len;
        if (w_acc) begin
            case (w_off)
                REG_CTRL: begin
                    if (req_write_i) begin
                        if (req_wstrb_i != 4'hF) begin
                            w_err = 1'b1;
                        end else begin
                            w_start = req_wdata_i[CTRL_START_BIT];
                            w_stop  = req_wdata_i[CTRL_STOP_BIT];
                        end
                    end
                end
                REG_TRACE_LEN: begin
                    if (req_write_i) begin
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (req_wstrb_i[b]) begin
                                w_len32[8*b +: 8] = req_wdata_i[8*b +: 8];
                            end
                        end
                        w_len_nxt = LenWidth'(w_len32);
                    end else begin
                        w_rdata = 32'(r_trace_len);
                    end
                end
                REG_EXIT: begin
                    if (req_write_i) begin
                        if ((req_wstrb_i != 4'hF) || !req_wdata_i[0] || r_eoc_valid) begin
                            w_err = 1'b1;
                        end else begin
                            w_exit = 1'b1;
                        end
                    end
                end
                REG_STATUS: begin
                    if (!req_write_i) begin
                        w_rdata = w_status;
                    end
                end
                REG_WIN_CNT: begin
                    if (!req_write_i) begin
                        w_rdata = 32'(w_win_cnt);
                    end
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    // Response register: loaded on acceptance, held until the master takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_error <= w_err;
        end else if (r_rsp_valid && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end
    end

    // Command pulses to the window FSM and TRACE_LEN storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_close     <= 1'b0;
            r_trace_len <= '0;
        end else begin
            r_start     <= w_start;
            r_stop      <= w_stop;
            r_close     <= w_exit;
            r_trace_len <= w_len_nxt;
        end
    end

    // EOC flag and exit code; code is kept after acknowledge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_eoc_valid <= 1'b0;
            r_exit_code <= '0;
        end else if (w_exit) begin
            r_eoc_valid <= 1'b1;
            r_exit_code <= req_wdata_i[31:1];
        end else if (r_eoc_valid && eoc_ack_i) begin
            r_eoc_valid <= 1'b0;
        end
    end

    sim_trace_window_cnt #(
        .LenWidth      (LenWidth),
        .CntWidth      (CntWidth),
        .HoldoffCycles (HoldoffCycles)
    ) u_win (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_start      (r_start),
        .i_stop       (r_stop),
        .i_close      (r_close),
        .i_trace_len  (r_trace_len),
        .o_state      (w_state),
        .o_start_pend (w_start_pend),
        .o_trace_en   (trace_en_o),
        .o_win_cnt    (w_win_cnt),
        .o_windows    (w_windows)
    );

    assign req_ready_o = !r_rsp_valid;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_error_o = r_rsp_error;
    assign eoc_valid_o = r_eoc_valid;
    assign exit_code_o = r_exit_code;

endmodule

// File: tb/tb_sim_eoc_trace_ctrl.sv
// Directed bench for sim_eoc_trace_ctrl.
module tb_sim_eoc_trace_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        trace_en_o;
    logic        eoc_valid_o;
    logic        eoc_ack_i = 1'b0;
    logic [30:0] exit_code_o;

    int tests = 0;
    int fails = 0;

    sim_eoc_trace_ctrl #(
        .AddrWidth     (32),
        .LenWidth      (32),
        .CntWidth      (16),
        .HoldoffCycles (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .trace_en_o  (trace_en_o),
        .eoc_valid_o (eoc_valid_o),
        .eoc_ack_i   (eoc_ack_i),
        .exit_code_o (exit_code_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One register access; returns at the negedge where the response is visible
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = data;
        req_wstrb_i = strb;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (rsp_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL access_rsp_valid addr=%h got %b want 1", addr, rsp_valid_o);
        end
        rdata = rsp_rdata_o;
        err   = rsp_error_o;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        repeat (3) @(negedge clk_i);
        tests++;
        if ({req_ready_o, rsp_valid_o, trace_en_o, eoc_valid_o, rsp_error_o} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_outputs got %b want 10000",
                     {req_ready_o, rsp_valid_o, trace_en_o, eoc_valid_o, rsp_error_o});
        end
        tests++;
        if (exit_code_o !== 31'd0 || rsp_rdata_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_data exit=%h rdata=%h want 0", exit_code_o, rsp_rdata_o);
        end
        rst_ni = 1'b1;
        access(1'b0, 32'h4, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            fails++;
            $display("FAIL reset_trace_len got %h/%b want 0/0", rd, er);
        end
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL reset_status got %h want 0", rd);
        end
    endtask

    task automatic test_len_window();
        logic [31:0] rd;
        logic        er;
        int          high;
        int          rises;
        logic        prev;
        access(1'b1, 32'h4, 32'd10, 4'hF, rd, er);
        access(1'b1, 32'h0, 32'h1, 4'hF, rd, er);
        high = 0;
        rises = 0;
        prev = trace_en_o;
        repeat (25) begin
            @(negedge clk_i);
            if (trace_en_o) high++;
            if (trace_en_o && !prev) rises++;
            prev = trace_en_o;
        end
        tests++;
        if (high != 10 || rises != 1) begin
            fails++;
            $display("FAIL len_window high=%0d rises=%0d want 10/1", high, rises);
        end
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0001_0000) begin
            fails++;
            $display("FAIL len_status got %h want 00010000", rd);
        end
        access(1'b0, 32'h10, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'd10) begin
            fails++;
            $display("FAIL len_win_cnt got %0d want 10", rd);
        end
    endtask

    task automatic test_stop_unlimited();
        logic [31:0] rd;
        logic        er;
        access(1'b1, 32'h4, 32'd0, 4'hF, rd, er);
        access(1'b1, 32'h0, 32'h1, 4'hF, rd, er);
        @(negedge clk_i);
        tests++;
        if (trace_en_o !== 1'b1) begin
            fails++;
            $display("FAIL unl_open got %b want 1", trace_en_o);
        end
        repeat (99) @(negedge clk_i);
        access(1'b1, 32'h0, 32'h2, 4'hF, rd, er);
        tests++;
        if (trace_en_o !== 1'b1) begin
            fails++;
            $display("FAIL unl_stop_cycle got %b want 1", trace_en_o);
        end
        @(negedge clk_i);
        tests++;
        if (trace_en_o !== 1'b0) begin
            fails++;
            $display("FAIL unl_stop_fall got %b want 0", trace_en_o);
        end
        repeat (8) @(negedge clk_i);
        access(1'b0, 32'h10, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'd102) begin
            fails++;
            $display("FAIL unl_win_cnt got %0d want 102", rd);
        end
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0002_0000) begin
            fails++;
            $display("FAIL unl_status got %h want 00020000", rd);
        end
    endtask

    task automatic test_start_in_holdoff();
        logic [31:0] rd;
        logic        er;
        access(1'b1, 32'h0, 32'h1, 4'hF, rd, er);
        repeat (3) @(negedge clk_i);
        access(1'b1, 32'h0, 32'h2, 4'hF, rd, er);
        access(1'b1, 32'h0, 32'h1, 4'hF, rd, er);
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0003_000A) begin
            fails++;
            $display("FAIL ho_status_pend got %h want 0003000a", rd);
        end
        tests++;
        if (trace_en_o !== 1'b0) begin
            fails++;
            $display("FAIL ho_low4 got %b want 0", trace_en_o);
        end
        @(negedge clk_i);
        tests++;
        if (trace_en_o !== 1'b0) begin
            fails++;
            $display("FAIL ho_low5 got %b want 0", trace_en_o);
        end
        @(negedge clk_i);
        tests++;
        if (trace_en_o !== 1'b1) begin
            fails++;
            $display("FAIL ho_rise got %b want 1", trace_en_o);
        end
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0004_0001) begin
            fails++;
            $display("FAIL ho_status_active got %h want 00040001", rd);
        end
        access(1'b1, 32'h0, 32'h2, 4'hF, rd, er);
        repeat (10) @(negedge clk_i);
    endtask

    task automatic test_exit();
        logic [31:0] rd;
        logic        er;
        access(1'b1, 32'h0, 32'h1, 4'hF, rd, er);
        repeat (3) @(negedge clk_i);
        access(1'b1, 32'h8, 32'h0000_0007, 4'hF, rd, er);
        tests++;
        if (er !== 1'b0 || eoc_valid_o !== 1'b1 || exit_code_o !== 31'd3) begin
            fails++;
            $display("FAIL exit_first err=%b eoc=%b code=%0d want 0/1/3", er, eoc_valid_o, exit_code_o);
        end
        @(negedge clk_i);
        tests++;
        if (trace_en_o !== 1'b0) begin
            fails++;
            $display("FAIL exit_close got %b want 0", trace_en_o);
        end
        access(1'b1, 32'h8, 32'h0000_0009, 4'hF, rd, er);
        tests++;
        if (er !== 1'b1 || rd !== 32'd0 || exit_code_o !== 31'd3 || eoc_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL exit_second err=%b rd=%h code=%0d eoc=%b want 1/0/3/1",
                     er, rd, exit_code_o, eoc_valid_o);
        end
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if ((rd & 32'h4) !== 32'h4) begin
            fails++;
            $display("FAIL exit_status_eoc got %h want bit2 set", rd);
        end
        eoc_ack_i = 1'b1;
        @(negedge clk_i);
        eoc_ack_i = 1'b0;
        tests++;
        if (eoc_valid_o !== 1'b0 || exit_code_o !== 31'd3) begin
            fails++;
            $display("FAIL exit_ack eoc=%b code=%0d want 0/3", eoc_valid_o, exit_code_o);
        end
        repeat (8) @(negedge clk_i);
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0005_0000) begin
            fails++;
            $display("FAIL exit_status_after got %h want 00050000", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        access(1'b1, 32'h8, 32'h0000_0006, 4'hF, rd, er);
        tests++;
        if (er !== 1'b1 || eoc_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL err_exit_bit0 err=%b eoc=%b want 1/0", er, eoc_valid_o);
        end
        access(1'b1, 32'h0, 32'h1, 4'h3, rd, er);
        tests++;
        if (er !== 1'b1) begin
            fails++;
            $display("FAIL err_ctrl_strb got %b want 1", er);
        end
        repeat (3) @(negedge clk_i);
        tests++;
        if (trace_en_o !== 1'b0) begin
            fails++;
            $display("FAIL err_ctrl_noeffect got %b want 0", trace_en_o);
        end
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0005_0000) begin
            fails++;
            $display("FAIL err_status got %h want 00050000", rd);
        end
        access(1'b0, 32'h14, '0, 4'h0, rd, er);
        tests++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            fails++;
            $display("FAIL err_addr14 err=%b rd=%h want 1/0", er, rd);
        end
        access(1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, rd, er);
        tests++;
        if (er !== 1'b1) begin
            fails++;
            $display("FAIL err_addr1c got %b want 1", er);
        end
        access(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, rd, er);
        access(1'b1, 32'h4, 32'h1234_5678, 4'b0101, rd, er);
        access(1'b0, 32'h4, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'hFF34_FF78 || er !== 1'b0) begin
            fails++;
            $display("FAIL len_wstrb got %h/%b want ff34ff78/0", rd, er);
        end
    endtask

    task automatic test_backpressure_reset();
        logic [31:0] rd;
        logic        er;
        int          bad;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 32'h4;
        @(posedge clk_i);
        #1;
        req_addr_i  = 32'hC;
        bad = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || rsp_rdata_o !== 32'hFF34_FF78) bad++;
        end
        req_valid_i = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold bad_cycles=%0d want 0", bad);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_release valid=%b ready=%b want 0/1", rsp_valid_o, req_ready_o);
        end
        access(1'b1, 32'h0, 32'h1, 4'hF, rd, er);
        @(negedge clk_i);
        tests++;
        if (trace_en_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_active got %b want 1", trace_en_o);
        end
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h4;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({trace_en_o, rsp_valid_o, req_ready_o, eoc_valid_o} !== 4'b0010 || exit_code_o !== 31'd0) begin
            fails++;
            $display("FAIL rst_async got %b code=%0d want 0010 code=0",
                     {trace_en_o, rsp_valid_o, req_ready_o, eoc_valid_o}, exit_code_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        access(1'b0, 32'h4, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL rst_trace_len got %h want 0", rd);
        end
        access(1'b0, 32'hC, '0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL rst_status got %h want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_len_window();
        test_stop_unlimited();
        test_start_in_holdoff();
        test_exit();
        test_errors();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
